// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

endpackage

// File: rtl/full_adder.sv
// One full-adder slice built from two half-adder cells and an OR of their carries.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  logic s1;
  logic c1;
  logic c2;

  halfadder ha0 (
    .a     (a),
    .b     (b),
    .sum   (s1),
    .carry (c1)
  );

  halfadder ha1 (
    .a     (s1),
    .b     (cin),
    .sum   (sum),
    .carry (c2)
  );

  assign carry = c1 | c2;

endmodule

// File: rtl/halfadder.sv
// Team half-adder cell: one-bit sum and carry of two inputs.
module halfadder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_adder16.sv
// Bit-serial two's-complement adder: one full-adder slice reused per clock, LSB first,
// with valid/ready handshakes on operands and result plus zr/ng flags.
module serial_adder16
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             zr,
  output logic             ng,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic             carry_reg;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             fa_sum;
  logic             fa_carry;

  full_adder slice (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .cin   (carry_reg),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // Each RUN edge retires one bit; the sum enters at the MSB and walks down to bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      carry_reg <= 1'b0;
      sum_sh    <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh      <= a;
            b_sh      <= b;
            carry_reg <= cin;
            count     <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          sum_sh    <= {fa_sum, sum_sh[WIDTH-1:1]};
          a_sh      <= a_sh >> 1;
          b_sh      <= b_sh >> 1;
          carry_reg <= fa_carry;
          if (count == LAST) begin
            state <= DONE;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode straight from the state register so reset clears them at once.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_sh;
  assign carry     = carry_reg;
  assign zr        = (sum_sh == '0);
  assign ng        = sum_sh[WIDTH-1];

endmodule
